serial_xnor_cmp: RTL and testbench
==================================

Name: serial_xnor_cmp

Overview:
- Bit-serial equality comparator that directly consumes the per-bit XNOR (equivalence) result.
- Two operands arrive one bit per clock. Each bit pair passes through a NAND-only XNOR cell and is ANDed into a running equality flag.
- After WIDTH accepted bits the block pulses done and reports whether the two words were identical.
- Sits downstream of the XNOR gate stage in the guide's datapath and feeds status to later control logic.

Parameters:
- WIDTH, 8, number of bit pairs per comparison; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a new comparison; sampled only in IDLE.
- bit_valid  input  1  a_bit/b_bit hold a valid pair this cycle.
- a_bit  input  1  serial operand A, LSB first.
- b_bit  input  1  serial operand B, LSB first.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when the result is ready.
- equal  output  1  1 if all WIDTH pairs matched; valid from done, held until next start.

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE; busy=0, done=0, equal=0.
  - bit counter=0, accumulator acc_eq=1.
  - rst overrides every other input in the same cycle.
- States: IDLE, SHIFT, DONE; registered Moore outputs.
- IDLE:
  - start=1 -> SHIFT; counter cleared, acc_eq set to 1, equal cleared to 0.
  - bit_valid is ignored in IDLE.
- SHIFT (busy=1):
  - Each cycle with bit_valid=1: acc_eq <= acc_eq & xnor(a_bit, b_bit); counter increments.
  - bit_valid=0: stall; counter and acc_eq unchanged; no timeout.
  - The pair accepted when counter==WIDTH-1 is the last one -> DONE next cycle.
- DONE:
  - done=1 for exactly one cycle; equal <= final acc_eq; busy=0.
  - Unconditional return to IDLE.
  - start asserted during DONE is ignored; it must be re-asserted in IDLE.
- start while busy or in DONE: ignored; the comparison in flight is unaffected.
- Latency: start sampled at edge 0 with bit_valid continuously high from the next cycle -> done high in cycle WIDTH+1. Each stall cycle adds 1.
- Counter width: $clog2(WIDTH). Wrap is impossible because the counter leaves SHIFT at WIDTH-1.
- rst during SHIFT: comparison aborted, no done pulse, equal=0.

Optional Feature:
- Macro: SERIAL_XNOR_CMP_MISMATCH_CNT_EN.
- Defined:
  - Adds output mismatches, width $clog2(WIDTH+1).
  - Cleared on start and on rst; increments on each accepted pair whose XNOR is 0.
  - Final value valid with done and held until the next start.
- Undefined: no port and no counter logic; all other behaviour identical.

Decomposition:
- Package serial_xnor_cmp_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - the WIDTH legal-range limits.
- One sub-module, xnor_nand_cell (output s, inputs a, b):
  - Combinational XNOR built from five 2-input NANDs.
  - Instantiated once on a_bit/b_bit; its output feeds acc_eq.
  - No behavioural XNOR operator anywhere in the parent.

Test Plan (WIDTH=8):
- start, then A=8'hA5 and B=8'hA5 with bit_valid constantly high -> done in cycle 9, equal=1, mismatches=0.
- A=8'hA5, B=8'hA4 -> done in cycle 9, equal=0, mismatches=1.
- A=8'h00, B=8'hFF with bit_valid low for 3 cycles after bit 3 -> done in cycle 12, equal=0, mismatches=8.
- rst=1 for one cycle after 4 bits accepted -> busy=0 next cycle, no done pulse, equal=0; a new start and an 8-bit equal pair then give equal=1.
- start pulsed again mid-SHIFT and during DONE -> ignored; a single done is produced and the state returns to IDLE.
- Back-to-back: start in the first IDLE cycle after DONE -> second comparison runs correctly and equal from the first comparison holds until that start.

Source files
------------

// File: rtl/serial_xnor_cmp_pkg.sv
// Shared state encoding and parameter limits for the bit-serial equality comparator.
package serial_xnor_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/xnor_nand_cell.sv
// Combinational XNOR built only from five 2-input NAND gates.
module xnor_nand_cell (
    input  logic a,
    input  logic b,
    output logic s
);

    logic n_ab;
    logic n_a;
    logic n_b;
    logic x_or;

    // Classic four-NAND XOR, then a fifth NAND wired as an inverter.
    assign n_ab = ~(a & b);
    assign n_a  = ~(a & n_ab);
    assign n_b  = ~(b & n_ab);
    assign x_or = ~(n_a & n_b);
    assign s    = ~(x_or & x_or);

endmodule

// File: rtl/serial_xnor_cmp.sv
// Bit-serial equality comparator: ANDs per-bit XNOR results over WIDTH pairs.
// Optional mismatch counter enabled by defining SERIAL_XNOR_CMP_MISMATCH_CNT_EN.
module serial_xnor_cmp
    import serial_xnor_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done,
    output logic equal
`ifdef SERIAL_XNOR_CMP_MISMATCH_CNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] mismatches
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("serial_xnor_cmp: WIDTH out of range");
        end
    endgenerate

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic               acc_eq;
    logic               eq_bit;
    logic               accept;
    logic               last_bit;
    logic               start_ok;

    xnor_nand_cell u_xnor (
        .a (a_bit),
        .b (b_bit),
        .s (eq_bit)
    );

    assign start_ok = (state == ST_IDLE) && start;
    assign accept   = (state == ST_SHIFT) && bit_valid;
    assign last_bit = accept && (bit_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state, so they align with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == ST_SHIFT);
            done  <= (state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            acc_eq  <= 1'b1;
            equal   <= 1'b0;
        end else if (start_ok) begin
            bit_cnt <= '0;
            acc_eq  <= 1'b1;
            equal   <= 1'b0;
        end else if (accept) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            acc_eq  <= acc_eq & eq_bit;
            // equal is loaded on the edge that enters DONE so it is valid alongside done.
            if (last_bit) equal <= acc_eq & eq_bit;
        end
    end

`ifdef SERIAL_XNOR_CMP_MISMATCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            mismatches <= '0;
        end else if (accept && !eq_bit) begin
            mismatches <= mismatches + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_xnor_cmp.sv
// Directed self-checking bench for serial_xnor_cmp at WIDTH=8.
module tb_serial_xnor_cmp;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic equal;
`ifdef SERIAL_XNOR_CMP_MISMATCH_CNT_EN
    logic [3:0] mismatches;
`endif

    int total = 0;
    int bad   = 0;

    serial_xnor_cmp #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_valid (bit_valid),
        .a_bit     (a_bit),
        .b_bit     (b_bit),
        .busy      (busy),
        .done      (done),
        .equal     (equal)
`ifdef SERIAL_XNOR_CMP_MISMATCH_CNT_EN
        ,
        .mismatches(mismatches)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mm(input string tag, input int exp);
`ifdef SERIAL_XNOR_CMP_MISMATCH_CNT_EN
        chk(tag, 32'(mismatches), exp);
`endif
    endtask

    // Pulses start for one cycle; the DUT is in SHIFT afterwards.
    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_after_start"}, busy, 1);
        chk({tag, "_equal_cleared"}, equal, 0);
        chk_mm({tag, "_mm_cleared"}, 0);
    endtask

    // Feeds 8 bit pairs LSB first, ends in the DONE cycle.
    task automatic send_word(input logic [7:0] a, input logic [7:0] b, input int stall_at,
                             input int stall_n, input bit mid_start, input logic exp_eq,
                             input int exp_mm, input string tag);
        int cyc;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_n; s++) begin
                    bit_valid = 1'b0;
                    a_bit = ~a[i];
                    b_bit = b[i];
                    tick();
                    cyc++;
                    chk({tag, "_stall_busy"}, busy, 1);
                    chk({tag, "_stall_done"}, done, 0);
                end
            end
            bit_valid = 1'b1;
            a_bit = a[i];
            b_bit = b[i];
            start = mid_start && (i == 3);
            tick();
            cyc++;
            start = 1'b0;
            if (i < 7) chk({tag, "_early_done"}, done, 0);
        end
        bit_valid = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_in_done"}, busy, 0);
        chk({tag, "_equal"}, equal, exp_eq);
        chk({tag, "_latency"}, cyc + 1, 9 + stall_n);
        chk_mm({tag, "_mm"}, exp_mm);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        tick();
        start = 1'b1; bit_valid = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; bit_valid = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_equal", equal, 0);
        chk_mm("reset_mm", 0);

        // bit_valid in IDLE must not start anything
        bit_valid = 1'b1; a_bit = 1'b1;
        tick();
        bit_valid = 1'b0;
        chk("idle_valid_busy", busy, 0);

        // Equal pair
        do_start("t1");
        send_word(8'hA5, 8'hA5, 99, 0, 1'b0, 1'b1, 0, "t1");
        tick();
        chk("t1_done_pulse", done, 0);
        chk("t1_equal_held", equal, 1);
        tick();
        chk("t1_equal_held2", equal, 1);

        // Single-bit mismatch
        do_start("t2");
        send_word(8'hA5, 8'hA4, 99, 0, 1'b0, 1'b0, 1, "t2");
        tick();
        chk("t2_done_pulse", done, 0);

        // All bits differ, 3-cycle stall after bit 3
        do_start("t3");
        send_word(8'h00, 8'hFF, 4, 3, 1'b0, 1'b0, 8, "t3");
        tick();
        chk("t3_equal_held", equal, 0);
        chk_mm("t3_mm_held", 8);

        // Reset mid-comparison after 4 bits
        do_start("t4");
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1; a_bit = i[0]; b_bit = i[0];
            tick();
        end
        bit_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_rst_busy", busy, 0);
        chk("t4_rst_done", done, 0);
        chk("t4_rst_equal", equal, 0);
        bit_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_no_done", done, 0);
        end
        bit_valid = 1'b0;
        do_start("t4b");
        send_word(8'h3C, 8'h3C, 99, 0, 1'b0, 1'b1, 0, "t4b");

        // start mid-SHIFT and during DONE both ignored
        tick();
        do_start("t5");
        send_word(8'h81, 8'h01, 99, 0, 1'b1, 1'b0, 1, "t5");
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_done", done, 0);
        tick();
        chk("t5_start_in_done_ignored", busy, 0);
        chk("t5_no_second_done", done, 0);

        // Back-to-back: start in first IDLE cycle after DONE
        do_start("t6a");
        send_word(8'h5A, 8'h5A, 99, 0, 1'b0, 1'b1, 0, "t6a");
        tick();
        chk("t6_idle_equal_held", equal, 1);
        chk("t6_idle_busy", busy, 0);
        do_start("t6b");
        send_word(8'h5A, 8'hDB, 99, 0, 1'b0, 1'b0, 2, "t6b");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
